// File: rtl/control_sequencer_if.sv
// Bus bundle between the instruction decoder and the datapath strobes of the 8-bit CPU.
// The master modport drives run/IR/flags; the slave modport (the sequencer) drives the strobes.
interface control_sequencer_if #(
   parameter int ADDR_W = 4
);
   logic              run;
   logic [3:0]        ir_opcode;
   logic [ADDR_W-1:0] ir_operand;
   logic              flag_c;
   logic              flag_z;
   logic              pc_en;
   logic              pc_jmp;
   logic [ADDR_W-1:0] pc_jmploc;
   logic              pc_oe;
   logic              ram_oe;
   logic              ir_oe;
   logic              a_oe;
   logic              alu_oe;
   logic              mar_ld;
   logic              ir_ld;
   logic              a_ld;
   logic              b_ld;
   logic              out_ld;
   logic              flag_ld;
   logic              ram_we;
   logic              alu_sub;
   logic [2:0]        tstate;
   logic              halted;

   modport master (
      output run, ir_opcode, ir_operand, flag_c, flag_z,
      input  pc_en, pc_jmp, pc_jmploc, pc_oe, ram_oe, ir_oe, a_oe, alu_oe,
      input  mar_ld, ir_ld, a_ld, b_ld, out_ld, flag_ld, ram_we, alu_sub,
      input  tstate, halted
   );

   modport slave (
      input  run, ir_opcode, ir_operand, flag_c, flag_z,
      output pc_en, pc_jmp, pc_jmploc, pc_oe, ram_oe, ir_oe, a_oe, alu_oe,
      output mar_ld, ir_ld, a_ld, b_ld, out_ld, flag_ld, ram_we, alu_sub,
      output tstate, halted
   );
endinterface

// File: rtl/control_sequencer.sv
// Five-T-state microcode sequencer: strobes are a same-cycle decode of tstate/opcode/flags.
// run=0 freezes the T-state and blanks all strobes; HLT parks at T2 until reset.
module control_sequencer #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   control_sequencer_if.slave bus
);
   localparam logic [2:0] T0 = 3'd0;
   localparam logic [2:0] T1 = 3'd1;
   localparam logic [2:0] T2 = 3'd2;
   localparam logic [2:0] T3 = 3'd3;
   localparam logic [2:0] T4 = 3'd4;

   localparam logic [3:0] OP_LDA = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_STA = 4'b0100;
   localparam logic [3:0] OP_LDI = 4'b0101;
   localparam logic [3:0] OP_JMP = 4'b0110;
   localparam logic [3:0] OP_JC  = 4'b0111;
   localparam logic [3:0] OP_JZ  = 4'b1000;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   logic [2:0] tstate;
   logic       halted;
   logic       active;

   always_ff @(posedge clk) begin
      if (!rst) begin
         tstate <= T0;
         halted <= 1'b0;
      end else if (bus.run && !halted) begin
         // HLT parks the counter at T2 instead of advancing.
         if (tstate == T2 && bus.ir_opcode == OP_HLT) begin
            halted <= 1'b1;
         end else begin
            tstate <= (tstate == T4) ? T0 : tstate + 3'd1;
         end
      end
   end

   assign active     = rst && bus.run && !halted;
   assign bus.tstate = tstate;
   assign bus.halted = halted;
   assign bus.pc_jmploc = bus.pc_jmp ? bus.ir_operand : '0;

   always_comb begin
      bus.pc_en   = 1'b0;
      bus.pc_jmp  = 1'b0;
      bus.pc_oe   = 1'b0;
      bus.ram_oe  = 1'b0;
      bus.ir_oe   = 1'b0;
      bus.a_oe    = 1'b0;
      bus.alu_oe  = 1'b0;
      bus.mar_ld  = 1'b0;
      bus.ir_ld   = 1'b0;
      bus.a_ld    = 1'b0;
      bus.b_ld    = 1'b0;
      bus.out_ld  = 1'b0;
      bus.flag_ld = 1'b0;
      bus.ram_we  = 1'b0;
      bus.alu_sub = 1'b0;
      if (active) begin
         case (tstate)
            T0: begin
               bus.pc_oe  = 1'b1;
               bus.mar_ld = 1'b1;
            end
            T1: begin
               bus.ram_oe = 1'b1;
               bus.ir_ld  = 1'b1;
               bus.pc_en  = 1'b1;
            end
            T2: begin
               case (bus.ir_opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     bus.ir_oe  = 1'b1;
                     bus.mar_ld = 1'b1;
                  end
                  OP_LDI: begin
                     bus.ir_oe = 1'b1;
                     bus.a_ld  = 1'b1;
                  end
                  OP_JMP: bus.pc_jmp = 1'b1;
                  OP_JC:  bus.pc_jmp = bus.flag_c;
                  OP_JZ:  bus.pc_jmp = bus.flag_z;
                  OP_OUT: begin
                     bus.a_oe   = 1'b1;
                     bus.out_ld = 1'b1;
                  end
                  default: ;
               endcase
            end
            T3: begin
               case (bus.ir_opcode)
                  OP_LDA: begin
                     bus.ram_oe = 1'b1;
                     bus.a_ld   = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     bus.ram_oe  = 1'b1;
                     bus.b_ld    = 1'b1;
                     bus.alu_sub = (bus.ir_opcode == OP_SUB);
                  end
                  OP_STA: begin
                     bus.a_oe   = 1'b1;
                     bus.ram_we = 1'b1;
                  end
                  default: ;
               endcase
            end
            T4: begin
               if (bus.ir_opcode == OP_ADD || bus.ir_opcode == OP_SUB) begin
                  bus.alu_oe  = 1'b1;
                  bus.a_ld    = 1'b1;
                  bus.flag_ld = 1'b1;
                  bus.alu_sub = (bus.ir_opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
